// File: rtl/mem_rw_ctrl.sv
// Single-port RAM that sweeps every entry to CLEAR_VAL after reset, then serves reads in 1 or 2 cycles.
// Out-of-range writes are dropped and out-of-range reads return zero.
module mem_rw_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    MEM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int                    RD_LATENCY = 1,
    parameter int                    RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rd_valid,
    output logic                  busy
);
    typedef enum logic {CLEAR, READY} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MEM_DEPTH - 1);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_nxt;
    logic                  clr_we;
    logic                  in_range;
    logic                  rd_acc;
    logic                  wr_acc;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    generate
        if (MEM_DEPTH == (1 << ADDR_WIDTH)) begin : g_full
            assign in_range = 1'b1;
        end else begin : g_part
            assign in_range = (addr <= LAST_IDX);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        busy      = 1'b0;
        case (state)
            CLEAR: begin
                busy    = 1'b1;
                clr_we  = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST_IDX) begin
                    state_nxt = READY;
                end
            end
            default: ;
        endcase
    end

    assign rd_acc = rd && !busy;
    assign wr_acc = wr && !busy && in_range;

    // The array is read before this edge's write lands, so old data is the natural result.
    always_comb begin
        rd_word = '0;
        if (in_range) begin
            if (wr && (RDW_MODE != 0)) begin
                rd_word = din;
            end else begin
                rd_word = mem[addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt] <= CLEAR_VAL;
        end else if (wr_acc) begin
            mem[addr] <= din;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  s1_vld;
            logic [DATA_WIDTH-1:0] s1_dat;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_vld   <= 1'b0;
                    s1_dat   <= '0;
                    dout     <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    s1_vld   <= rd_acc;
                    rd_valid <= s1_vld;
                    if (rd_acc) begin
                        s1_dat <= rd_word;
                    end
                    if (s1_vld) begin
                        dout <= s1_dat;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout     <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_acc;
                    if (rd_acc) begin
                        dout <= rd_word;
                    end
                end
            end
        end
    endgenerate
endmodule
